// File: rtl/tm_qm0_depth_ctl_if.sv
// Handshake bundle between the QM0 depth requester, its clients (egress, scheduler)
// and the queue-depth tracker.
interface tm_qm0_depth_ctl_if #(
    parameter int QB = 3
);
    logic                 ep_enq_vld;
    logic [QB-1:0]        ep_enq_qid;
    logic                 ep_enq_rdy;
    logic                 sch_deq_vld;
    logic [QB-1:0]        sch_deq_qid;
    logic                 sch_deq_rdy;
    logic                 depth_enq_req;
    logic [QB-1:0]        depth_enq_qid;
    logic                 depth_deq_req;
    logic [QB-1:0]        depth_deq_qid;
    logic                 depth_enq_ack;
    logic                 depth_enq_to_empty;
    logic                 depth_deq_ack;
    logic                 depth_deq_from_emptyp2;
    logic                 act_set_vld;
    logic [QB-1:0]        act_set_qid;
    logic                 act_clr_vld;
    logic [QB-1:0]        act_clr_qid;
    logic [(2**QB)-1:0]   active;
    logic                 ack_err;

    modport slave (
        input  ep_enq_vld, ep_enq_qid, sch_deq_vld, sch_deq_qid,
               depth_enq_ack, depth_enq_to_empty, depth_deq_ack, depth_deq_from_emptyp2,
        output ep_enq_rdy, sch_deq_rdy, depth_enq_req, depth_enq_qid,
               depth_deq_req, depth_deq_qid, act_set_vld, act_set_qid,
               act_clr_vld, act_clr_qid, active, ack_err
    );

    modport master (
        output ep_enq_vld, ep_enq_qid, sch_deq_vld, sch_deq_qid,
               depth_enq_ack, depth_enq_to_empty, depth_deq_ack, depth_deq_from_emptyp2,
        input  ep_enq_rdy, sch_deq_rdy, depth_enq_req, depth_enq_qid,
               depth_deq_req, depth_deq_qid, act_set_vld, act_set_qid,
               act_clr_vld, act_clr_qid, active, ack_err
    );
endinterface

// File: rtl/tm_qm0_depth_ctl.sv
// QM0 depth-tracker requester: issues enq/deq requests, matches tracker acks back to
// their qids and maintains the per-queue ACTIVE (non-empty) bitmap.
module tm_qm0_depth_ctl #(
    parameter int QB        = 3,
    parameter int ENQ_CRED  = 4,
    parameter int DEQ_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    tm_qm0_depth_ctl_if.slave bus
);
    localparam int NQ  = 2 ** QB;
    localparam int CW  = $clog2(NQ + 3);
    localparam int CRW = $clog2(ENQ_CRED + 1);
    localparam int PW  = (ENQ_CRED > 1) ? $clog2(ENQ_CRED) : 1;
    localparam int BW  = $clog2(DEQ_BURST + 1);
    localparam logic [CW-1:0]  INIT_LAST = CW'(NQ + 1);
    localparam logic [CRW-1:0] CRED_FULL = CRW'(ENQ_CRED);
    localparam logic [BW-1:0]  BURST_MAX = BW'(DEQ_BURST);

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   init_cnt_r;
    logic            run_s;
    logic [CRW-1:0]  credits_r, credits_nxt_s;
    logic [QB-1:0]   tag_mem_r [ENQ_CRED];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [BW-1:0]   burst_r;
    logic            enq_req_r, deq_req_r;
    logic [QB-1:0]   enq_qid_r, deq_qid_r;
    logic [2:0]      pv_r;
    logic [QB-1:0]   pq_r [3];
    logic            set_vld_r, clr_vld_r, ack_err_r;
    logic [QB-1:0]   set_qid_r, clr_qid_r;
    logic [NQ-1:0]   active_r, set_mask_s, clr_mask_s;
    logic            enq_rdy_s, deq_rdy_s, enq_acc_s, deq_acc_s, outstanding_s;
    logic            enq_ack_ok_s, deq_ack_ok_s, ack_err_s, set_fire_s, clr_fire_s;
    logic [QB-1:0]   set_qid_s, clr_qid_s;

    // Handshake qualification and ack matching; no ack input reaches a ready or request.
    assign run_s         = (state_r == ST_RUN);
    assign outstanding_s = (credits_r != CRED_FULL);
    assign enq_rdy_s     = run_s & (credits_r != CRW'(0));
    assign deq_rdy_s     = run_s & ~((burst_r == BURST_MAX) & outstanding_s);
    assign enq_acc_s     = bus.ep_enq_vld & enq_rdy_s;
    assign deq_acc_s     = bus.sch_deq_vld & deq_rdy_s;
    assign enq_ack_ok_s  = bus.depth_enq_ack & outstanding_s;
    assign deq_ack_ok_s  = bus.depth_deq_ack & pv_r[2];
    assign ack_err_s     = (bus.depth_enq_ack & ~outstanding_s) | (bus.depth_deq_ack & ~pv_r[2]);
    assign set_fire_s    = enq_ack_ok_s & bus.depth_enq_to_empty;
    assign clr_fire_s    = deq_ack_ok_s & ~bus.depth_deq_from_emptyp2;
    assign set_qid_s     = tag_mem_r[rd_ptr_r];
    assign clr_qid_s     = pq_r[2];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: hold off traffic while the tracker clears its RAM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == INIT_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // RAM-clear cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_cnt_r <= CW'(0);
        end else if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + CW'(1);
        end
    end

    // Credit update and bitmap masks
    always_comb begin
        credits_nxt_s = credits_r;
        case ({enq_acc_s, enq_ack_ok_s})
            2'b10:   credits_nxt_s = credits_r - CRW'(1);
            2'b01:   credits_nxt_s = credits_r + CRW'(1);
            default: credits_nxt_s = credits_r;
        endcase
        if (set_fire_s) begin
            set_mask_s = NQ'(1) << set_qid_s;
        end else begin
            set_mask_s = {NQ{1'b0}};
        end
        if (clr_fire_s) begin
            clr_mask_s = NQ'(1) << clr_qid_s;
        end else begin
            clr_mask_s = {NQ{1'b0}};
        end
    end

    // Enqueue side: credits, in-order tag FIFO (pointer wrap needs power-of-two depth)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits_r <= CRED_FULL;
            wr_ptr_r  <= PW'(0);
            rd_ptr_r  <= PW'(0);
            enq_req_r <= 1'b0;
            enq_qid_r <= QB'(0);
            for (int i = 0; i < ENQ_CRED; i++) tag_mem_r[i] <= QB'(0);
        end else begin
            credits_r <= credits_nxt_s;
            enq_req_r <= enq_acc_s;
            enq_qid_r <= enq_acc_s ? bus.ep_enq_qid : QB'(0);
            if (enq_acc_s) begin
                tag_mem_r[wr_ptr_r] <= bus.ep_enq_qid;
                wr_ptr_r            <= wr_ptr_r + PW'(1);
            end
            if (enq_ack_ok_s) rd_ptr_r <= rd_ptr_r + PW'(1);
        end
    end

    // Dequeue side: burst throttle and qid pipe aligned to the fixed-latency deq ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_r   <= BW'(0);
            deq_req_r <= 1'b0;
            deq_qid_r <= QB'(0);
            pv_r      <= 3'b000;
            for (int i = 0; i < 3; i++) pq_r[i] <= QB'(0);
        end else begin
            burst_r   <= (deq_acc_s & outstanding_s) ? burst_r + BW'(1) : BW'(0);
            deq_req_r <= deq_acc_s;
            deq_qid_r <= deq_acc_s ? bus.sch_deq_qid : QB'(0);
            pv_r      <= {pv_r[1:0], deq_req_r};
            pq_r[0]   <= deq_qid_r;
            pq_r[1]   <= pq_r[0];
            pq_r[2]   <= pq_r[1];
        end
    end

    // ACTIVE bitmap (set wins over clear), transition events and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_r  <= {NQ{1'b0}};
            set_vld_r <= 1'b0;
            set_qid_r <= QB'(0);
            clr_vld_r <= 1'b0;
            clr_qid_r <= QB'(0);
            ack_err_r <= 1'b0;
        end else begin
            active_r  <= (active_r & ~clr_mask_s) | set_mask_s;
            set_vld_r <= set_fire_s;
            set_qid_r <= set_fire_s ? set_qid_s : QB'(0);
            clr_vld_r <= clr_fire_s;
            clr_qid_r <= clr_fire_s ? clr_qid_s : QB'(0);
            ack_err_r <= ack_err_r | ack_err_s;
        end
    end

    assign bus.ep_enq_rdy    = enq_rdy_s;
    assign bus.sch_deq_rdy   = deq_rdy_s;
    assign bus.depth_enq_req = enq_req_r;
    assign bus.depth_enq_qid = enq_qid_r;
    assign bus.depth_deq_req = deq_req_r;
    assign bus.depth_deq_qid = deq_qid_r;
    assign bus.act_set_vld   = set_vld_r;
    assign bus.act_set_qid   = set_qid_r;
    assign bus.act_clr_vld   = clr_vld_r;
    assign bus.act_clr_qid   = clr_qid_r;
    assign bus.active        = active_r;
    assign bus.ack_err       = ack_err_r;
endmodule

// File: tb/tb_tm_qm0_depth_ctl.sv
// Bench for tm_qm0_depth_ctl: directed vector table, multi-cycle corner sequences and
// a randomized run against a queue-based reference model.
module tb_tm_qm0_depth_ctl;
    localparam int QB        = 3;
    localparam int NQ        = 2 ** QB;
    localparam int ENQ_CRED  = 4;
    localparam int DEQ_BURST = 4;
    localparam int INIT_CYC  = NQ + 2;
    localparam int DEQ_LAT   = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    tm_qm0_depth_ctl_if #(.QB(QB)) bus ();

    tm_qm0_depth_ctl #(.QB(QB), .ENQ_CRED(ENQ_CRED), .DEQ_BURST(DEQ_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.ep_enq_vld             = 1'b0;
        bus.ep_enq_qid             = '0;
        bus.sch_deq_vld            = 1'b0;
        bus.sch_deq_qid            = '0;
        bus.depth_enq_ack          = 1'b0;
        bus.depth_enq_to_empty     = 1'b0;
        bus.depth_deq_ack          = 1'b0;
        bus.depth_deq_from_emptyp2 = 1'b0;
    endtask

    // Directed vectors: inputs applied before an edge, outputs expected after it.
    typedef struct {
        int ev, eq, dv, dq, ea, te, da, p2;
        int xer, xeq, xdr, xdq, xsv, xsq, xcv, xcq, xact, xerr, xerdy, xdrdy;
    } vec_t;

    function automatic vec_t mk(input int ev, eq, dv, dq, ea, te, da, p2,
                                input int xer, xeq, xdr, xdq, xsv, xsq, xcv, xcq,
                                input int xact, xerr, xerdy, xdrdy);
        vec_t v;
        v.ev = ev; v.eq = eq; v.dv = dv; v.dq = dq; v.ea = ea; v.te = te; v.da = da; v.p2 = p2;
        v.xer = xer; v.xeq = xeq; v.xdr = xdr; v.xdq = xdq;
        v.xsv = xsv; v.xsq = xsq; v.xcv = xcv; v.xcq = xcq;
        v.xact = xact; v.xerr = xerr; v.xerdy = xerdy; v.xdrdy = xdrdy;
        return v;
    endfunction

    vec_t vec [13];

    // Reference model state: outstanding enq tags, deq acks due by cycle, bitmap.
    typedef struct { int qid; int due; } dq_t;
    int          m_init, m_t, m_burst, m_err;
    int          m_tq [$];
    dq_t         m_dq [$];
    logic [NQ-1:0] m_act;
    int          x_er, x_eq, x_dr, x_dq, x_sv, x_sq, x_cv, x_cq;

    task automatic model_reset();
        m_init = INIT_CYC; m_t = 0; m_burst = 0; m_err = 0;
        m_tq.delete(); m_dq.delete(); m_act = '0;
        x_er = 0; x_eq = 0; x_dr = 0; x_dq = 0; x_sv = 0; x_sq = 0; x_cv = 0; x_cq = 0;
    endtask

    function automatic int m_erdy();
        return (m_init == 0 && m_tq.size() < ENQ_CRED) ? 1 : 0;
    endfunction

    function automatic int m_drdy();
        return (m_init == 0 && !(m_burst == DEQ_BURST && m_tq.size() != 0)) ? 1 : 0;
    endfunction

    task automatic model_step();
        int  eacc, dacc, busy, q;
        dq_t d;
        bit  have_due;
        eacc = (bus.ep_enq_vld && m_erdy() == 1) ? 1 : 0;
        dacc = (bus.sch_deq_vld && m_drdy() == 1) ? 1 : 0;
        busy = (m_tq.size() != 0) ? 1 : 0;
        x_sv = 0; x_sq = 0; x_cv = 0; x_cq = 0;
        if (bus.depth_enq_ack) begin
            if (m_tq.size() != 0) begin
                q = m_tq.pop_front();
                if (bus.depth_enq_to_empty) begin x_sv = 1; x_sq = q; end
            end else begin
                m_err = 1;
            end
        end
        have_due = 1'b0;
        if (m_dq.size() != 0 && m_dq[0].due == m_t) begin
            d = m_dq.pop_front();
            have_due = 1'b1;
        end
        if (bus.depth_deq_ack) begin
            if (have_due) begin
                if (!bus.depth_deq_from_emptyp2) begin x_cv = 1; x_cq = d.qid; end
            end else begin
                m_err = 1;
            end
        end
        m_burst = (dacc == 1 && busy == 1) ? m_burst + 1 : 0;
        if (eacc == 1) m_tq.push_back(int'(bus.ep_enq_qid));
        if (dacc == 1) begin
            d.qid = int'(bus.sch_deq_qid);
            d.due = m_t + 1 + DEQ_LAT;
            m_dq.push_back(d);
        end
        x_er = eacc; x_eq = (eacc == 1) ? int'(bus.ep_enq_qid) : 0;
        x_dr = dacc; x_dq = (dacc == 1) ? int'(bus.sch_deq_qid) : 0;
        if (x_cv == 1) m_act[x_cq] = 1'b0;
        if (x_sv == 1) m_act[x_sq] = 1'b1;
        if (m_init > 0) m_init--;
        m_t++;
    endtask

    task automatic check_model();
        chk("rnd_enq_rdy", int'(bus.ep_enq_rdy),    m_erdy());
        chk("rnd_deq_rdy", int'(bus.sch_deq_rdy),   m_drdy());
        chk("rnd_enq_req", int'(bus.depth_enq_req), x_er);
        chk("rnd_deq_req", int'(bus.depth_deq_req), x_dr);
        chk("rnd_set_vld", int'(bus.act_set_vld),   x_sv);
        chk("rnd_clr_vld", int'(bus.act_clr_vld),   x_cv);
        chk("rnd_active",  int'(bus.active),        int'(m_act));
        chk("rnd_ack_err", int'(bus.ack_err),       m_err);
        if (x_er == 1) chk("rnd_enq_qid", int'(bus.depth_enq_qid), x_eq);
        if (x_dr == 1) chk("rnd_deq_qid", int'(bus.depth_deq_qid), x_dq);
        if (x_sv == 1) chk("rnd_set_qid", int'(bus.act_set_qid),   x_sq);
        if (x_cv == 1) chk("rnd_clr_qid", int'(bus.act_clr_qid),   x_cq);
    endtask

    task automatic rnd_drive();
        bus.ep_enq_vld             = ($urandom_range(0, 9) < 6);
        bus.ep_enq_qid             = QB'($urandom_range(0, NQ - 1));
        bus.sch_deq_vld            = ($urandom_range(0, 9) < 5);
        bus.sch_deq_qid            = QB'($urandom_range(0, NQ - 1));
        bus.depth_enq_to_empty     = $urandom_range(0, 1) == 1;
        bus.depth_deq_from_emptyp2 = $urandom_range(0, 1) == 1;
        if (m_tq.size() != 0) bus.depth_enq_ack = ($urandom_range(0, 9) < 4);
        else                  bus.depth_enq_ack = ($urandom_range(0, 499) == 0);
        if (m_dq.size() != 0 && m_dq[0].due == m_t) bus.depth_deq_ack = 1'b1;
        else                                         bus.depth_deq_ack = ($urandom_range(0, 499) == 0);
    endtask

    initial begin
        int burst_exp [6];
        burst_exp = '{1, 1, 1, 1, 0, 1};

        vec[0]  = mk(0,0,0,0, 1,1,0,0,  0,0,0,0, 1,5,0,0, 'h20,0,1,1);
        vec[1]  = mk(0,0,1,5, 0,0,0,0,  0,0,1,5, 0,0,0,0, 'h20,0,1,1);
        vec[2]  = mk(0,0,0,0, 0,0,0,0,  0,0,0,0, 0,0,0,0, 'h20,0,1,1);
        vec[3]  = mk(0,0,0,0, 0,0,0,0,  0,0,0,0, 0,0,0,0, 'h20,0,1,1);
        vec[4]  = mk(0,0,0,0, 0,0,0,0,  0,0,0,0, 0,0,0,0, 'h20,0,1,1);
        vec[5]  = mk(0,0,0,0, 0,0,1,0,  0,0,0,0, 0,0,1,5, 'h00,0,1,1);
        vec[6]  = mk(1,3,1,3, 0,0,0,0,  1,3,1,3, 0,0,0,0, 'h00,0,1,1);
        vec[7]  = mk(0,0,0,0, 0,0,0,0,  0,0,0,0, 0,0,0,0, 'h00,0,1,1);
        vec[8]  = mk(0,0,0,0, 0,0,0,0,  0,0,0,0, 0,0,0,0, 'h00,0,1,1);
        vec[9]  = mk(0,0,0,0, 0,0,0,0,  0,0,0,0, 0,0,0,0, 'h00,0,1,1);
        vec[10] = mk(0,0,0,0, 1,1,1,0,  0,0,0,0, 1,3,1,3, 'h08,0,1,1);
        vec[11] = mk(0,0,0,0, 0,0,1,0,  0,0,0,0, 0,0,0,0, 'h08,1,1,1);
        vec[12] = mk(0,0,0,0, 0,0,0,0,  0,0,0,0, 0,0,0,0, 'h08,1,1,1);

        idle();
        repeat (2) @(negedge clk);
        chk("rst_enq_rdy", int'(bus.ep_enq_rdy),    0);
        chk("rst_deq_rdy", int'(bus.sch_deq_rdy),   0);
        chk("rst_enq_req", int'(bus.depth_enq_req), 0);
        chk("rst_deq_req", int'(bus.depth_deq_req), 0);
        chk("rst_set_vld", int'(bus.act_set_vld),   0);
        chk("rst_clr_vld", int'(bus.act_clr_vld),   0);
        chk("rst_active",  int'(bus.active),        0);
        chk("rst_ack_err", int'(bus.ack_err),       0);

        // RAM-clear window with an enqueue already waiting
        reset = 1'b0;
        bus.ep_enq_vld = 1'b1;
        bus.ep_enq_qid = QB'(5);
        for (int i = 0; i < INIT_CYC; i++) begin
            chk("init_enq_rdy", int'(bus.ep_enq_rdy),    0);
            chk("init_deq_rdy", int'(bus.sch_deq_rdy),   0);
            chk("init_enq_req", int'(bus.depth_enq_req), 0);
            @(negedge clk);
        end
        chk("run_enq_rdy",   int'(bus.ep_enq_rdy),    1);
        chk("run_enq_req0",  int'(bus.depth_enq_req), 0);
        @(negedge clk);
        chk("first_enq_req", int'(bus.depth_enq_req), 1);
        chk("first_enq_qid", int'(bus.depth_enq_qid), 5);
        bus.ep_enq_vld = 1'b0;

        for (int i = 0; i < 13; i++) begin
            bus.ep_enq_vld             = vec[i].ev[0];
            bus.ep_enq_qid             = vec[i].eq[QB-1:0];
            bus.sch_deq_vld            = vec[i].dv[0];
            bus.sch_deq_qid            = vec[i].dq[QB-1:0];
            bus.depth_enq_ack          = vec[i].ea[0];
            bus.depth_enq_to_empty     = vec[i].te[0];
            bus.depth_deq_ack          = vec[i].da[0];
            bus.depth_deq_from_emptyp2 = vec[i].p2[0];
            @(negedge clk);
            chk($sformatf("vec%0d_enq_req", i), int'(bus.depth_enq_req), vec[i].xer);
            chk($sformatf("vec%0d_enq_qid", i), int'(bus.depth_enq_qid), vec[i].xeq);
            chk($sformatf("vec%0d_deq_req", i), int'(bus.depth_deq_req), vec[i].xdr);
            chk($sformatf("vec%0d_deq_qid", i), int'(bus.depth_deq_qid), vec[i].xdq);
            chk($sformatf("vec%0d_set_vld", i), int'(bus.act_set_vld),   vec[i].xsv);
            chk($sformatf("vec%0d_set_qid", i), int'(bus.act_set_qid),   vec[i].xsq);
            chk($sformatf("vec%0d_clr_vld", i), int'(bus.act_clr_vld),   vec[i].xcv);
            chk($sformatf("vec%0d_clr_qid", i), int'(bus.act_clr_qid),   vec[i].xcq);
            chk($sformatf("vec%0d_active",  i), int'(bus.active),        vec[i].xact);
            chk($sformatf("vec%0d_ack_err", i), int'(bus.ack_err),       vec[i].xerr);
            chk($sformatf("vec%0d_enq_rdy", i), int'(bus.ep_enq_rdy),    vec[i].xerdy);
            chk($sformatf("vec%0d_deq_rdy", i), int'(bus.sch_deq_rdy),   vec[i].xdrdy);
        end
        idle();

        // Credit exhaustion: four enqs with acks held off, then a single ack
        bus.ep_enq_vld = 1'b1;
        for (int i = 0; i < ENQ_CRED; i++) begin
            bus.ep_enq_qid = QB'(i);
            chk("cred_rdy", int'(bus.ep_enq_rdy), 1);
            @(negedge clk);
        end
        chk("cred_full_rdy", int'(bus.ep_enq_rdy),    0);
        chk("cred_req4",     int'(bus.depth_enq_req), 1);
        @(negedge clk);
        chk("cred_stall_req", int'(bus.depth_enq_req), 0);
        chk("cred_stall_rdy", int'(bus.ep_enq_rdy),    0);
        bus.depth_enq_ack = 1'b1;
        @(negedge clk);
        chk("cred_ack_rdy",   int'(bus.ep_enq_rdy),    1);
        chk("cred_ack_noreq", int'(bus.depth_enq_req), 0);
        bus.ep_enq_vld = 1'b0;
        repeat (ENQ_CRED - 1) @(negedge clk);
        bus.depth_enq_ack = 1'b0;
        @(negedge clk);
        chk("cred_drain_rdy",    int'(bus.ep_enq_rdy), 1);
        chk("cred_drain_active", int'(bus.active),     'h08);
        chk("cred_drain_err",    int'(bus.ack_err),    1);

        // Deq burst throttle with one enq outstanding
        bus.ep_enq_vld = 1'b1;
        bus.ep_enq_qid = QB'(1);
        @(negedge clk);
        bus.ep_enq_vld  = 1'b0;
        bus.sch_deq_vld = 1'b1;
        bus.sch_deq_qid = QB'(2);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("burst%0d_deq_rdy", i), int'(bus.sch_deq_rdy), burst_exp[i]);
            @(negedge clk);
        end
        bus.sch_deq_vld   = 1'b0;
        bus.depth_enq_ack = 1'b1;
        @(negedge clk);
        bus.depth_enq_ack = 1'b0;

        // Asynchronous reset in the middle of traffic
        bus.sch_deq_vld = 1'b1;
        bus.ep_enq_vld  = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_active",  int'(bus.active),      0);
        chk("mid_rst_ack_err", int'(bus.ack_err),     0);
        chk("mid_rst_enq_rdy", int'(bus.ep_enq_rdy),  0);
        chk("mid_rst_deq_rdy", int'(bus.sch_deq_rdy), 0);
        @(negedge clk);
        idle();
        reset = 1'b0;
        model_reset();

        for (int c = 0; c < 4000; c++) begin
            check_model();
            rnd_drive();
            model_step();
            @(negedge clk);
        end
        check_model();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
